// File: rtl/hwpe_ctrl_uloop_sched_pkg.sv
// Shared types for the HWPE micro-loop scheduler.
// Holds the uloop control/flag bundles and the scheduler state enum.
package hwpe_ctrl_uloop_sched_pkg;

  localparam int ULOOP_SCHED_MAX_STREAMERS = 8;
  localparam int ULOOP_NB_LOOPS = 2;
  localparam int ULOOP_NB_REG   = 2;
  localparam int ULOOP_IDX_W    = 16;

  typedef struct packed {
    logic enable;
    logic clear;
    logic ready;
  } ctrl_uloop_t;

  typedef struct packed {
    logic                                      valid;
    logic                                      done;
    logic [ULOOP_NB_LOOPS-1:0]                 loop;
    logic [ULOOP_NB_REG-1:0][31:0]             offs;
    logic [ULOOP_NB_LOOPS-1:0][ULOOP_IDX_W-1:0] idx;
  } flags_uloop_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ISSUE,
    STALL,
    DRAIN,
    FINISH
  } uloop_sched_state_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_sched_credit_cnt.sv
// Up/down saturating credit counter with sticky underflow flag.
// Simultaneous increment and decrement leave the count unchanged.
module hwpe_ctrl_credit_cnt #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX+1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         err_o
);

  logic uflow;

  // next count and underflow detection
  always_comb begin
    cnt_next_o = cnt_o;
    uflow      = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_o != W'(MAX))
        cnt_next_o = cnt_o + W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_o == '0)
        uflow = 1'b1;
      else
        cnt_next_o = cnt_o - W'(1);
    end
  end

  // count register and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
      err_o <= 1'b0;
    end else if (clear_i) begin
      cnt_o <= '0;
      err_o <= 1'b0;
    end else begin
      cnt_o <= cnt_next_o;
      if (uflow)
        err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/hwpe_ctrl_uloop_sched.sv
// Micro-loop sequencer: steps the uloop, broadcasts offsets, throttles by credits.
// Optional HWPE_CTRL_ULOOP_SCHED_PERF_EN adds the perf_stall_o cycle counter.
module hwpe_ctrl_uloop_sched
  import hwpe_ctrl_uloop_sched_pkg::*;
#(
  parameter int NB_STREAMERS = 4,
  parameter int MAX_CREDITS  = 2,
  parameter int CRED_WIDTH   = $clog2(MAX_CREDITS+1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output ctrl_uloop_t             uloop_ctrl_o,
  input  flags_uloop_t            uloop_flags_i,
  output logic [NB_STREAMERS-1:0] iter_valid_o,
  input  logic [NB_STREAMERS-1:0] iter_ready_i,
  output flags_uloop_t            iter_flags_o,
  output logic                    iter_last_o,
  input  logic                    compute_done_i,
  output logic [CRED_WIDTH-1:0]   credits_o,
  output logic                    err_o
`ifdef HWPE_CTRL_ULOOP_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_stall_o
`endif
);

  uloop_sched_state_t state;

  logic [NB_STREAMERS-1:0] acc;
  logic [NB_STREAMERS-1:0] acc_n;
  logic                    issue_exit;
  logic [CRED_WIDTH-1:0]   cred_next;
  logic                    unused_tm;

  assign unused_tm  = test_mode_i;
  assign acc_n      = acc | (iter_valid_o & iter_ready_i);
  assign issue_exit = (state == ISSUE) && (&acc_n);

  hwpe_ctrl_credit_cnt #(
    .MAX (MAX_CREDITS),
    .W   (CRED_WIDTH)
  ) i_cred (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .inc_i      (issue_exit),
    .dec_i      (compute_done_i),
    .cnt_o      (credits_o),
    .cnt_next_o (cred_next),
    .err_o      (err_o)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      uloop_ctrl_o <= '0;
      iter_valid_o <= '0;
      acc          <= '0;
      iter_flags_o <= '0;
      iter_last_o  <= 1'b0;
    end else if (clear_i) begin
      state              <= IDLE;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      uloop_ctrl_o       <= '0;
      uloop_ctrl_o.clear <= 1'b1;
      iter_valid_o       <= '0;
      acc                <= '0;
      iter_flags_o       <= '0;
      iter_last_o        <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      uloop_ctrl_o <= '0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state               <= REQ;
            busy_o              <= 1'b1;
            uloop_ctrl_o.enable <= 1'b1;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (uloop_flags_i.valid) begin
            iter_flags_o <= uloop_flags_i;
            iter_last_o  <= uloop_flags_i.done;
            iter_valid_o <= '1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (&acc_n) begin
            acc          <= '0;
            iter_valid_o <= '0;
            if (iter_last_o) begin
              state <= DRAIN;
            end else if (cred_next < CRED_WIDTH'(MAX_CREDITS)) begin
              state               <= REQ;
              uloop_ctrl_o.enable <= 1'b1;
            end else begin
              state <= STALL;
            end
          end else begin
            acc          <= acc_n;
            iter_valid_o <= ~acc_n;
          end
        end
        STALL: begin
          if (credits_o < CRED_WIDTH'(MAX_CREDITS)) begin
            state               <= REQ;
            uloop_ctrl_o.enable <= 1'b1;
          end
        end
        DRAIN: begin
          if (credits_o == '0) begin
            state              <= FINISH;
            done_o             <= 1'b1;
            uloop_ctrl_o.clear <= 1'b1;
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HWPE_CTRL_ULOOP_SCHED_PERF_EN
  // cycles spent waiting on the uloop or on credits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_o <= '0;
    end else if (clear_i) begin
      perf_stall_o <= '0;
    end else if (state == IDLE && start_i) begin
      perf_stall_o <= '0;
    end else if (busy_o && (state == WAIT || state == STALL)
                 && perf_stall_o != '1) begin
      perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hwpe_ctrl_uloop_sched.sv
// Self-checking bench for hwpe_ctrl_uloop_sched.
// Table-driven job trace plus directed handshake/credit/clear sequences.
module tb_hwpe_ctrl_uloop_sched;
  import hwpe_ctrl_uloop_sched_pkg::*;

  localparam int NB = 2;
  localparam int MC = 2;
  localparam int CW = $clog2(MC+1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          test_mode_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o;
  ctrl_uloop_t   uloop_ctrl_o;
  flags_uloop_t  fl;
  logic [NB-1:0] iter_valid_o;
  logic [NB-1:0] iter_ready_i = '1;
  flags_uloop_t  iter_flags_o;
  logic          iter_last_o;
  logic          compute_done_i = 1'b0;
  logic [CW-1:0] credits_o;
  logic          err_o;
`ifdef HWPE_CTRL_ULOOP_SCHED_PERF_EN
  logic [31:0]   perf_stall_o;
`endif

  hwpe_ctrl_uloop_sched #(
    .NB_STREAMERS (NB),
    .MAX_CREDITS  (MC)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .test_mode_i    (test_mode_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .uloop_ctrl_o   (uloop_ctrl_o),
    .uloop_flags_i  (fl),
    .iter_valid_o   (iter_valid_o),
    .iter_ready_i   (iter_ready_i),
    .iter_flags_o   (iter_flags_o),
    .iter_last_o    (iter_last_o),
    .compute_done_i (compute_done_i),
    .credits_o      (credits_o),
    .err_o          (err_o)
`ifdef HWPE_CTRL_ULOOP_SCHED_PERF_EN
    ,
    .perf_stall_o   (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int nit = 3;
  int dly = 0;
  int it;
  int dcnt;
  logic pend;

  // uloop model: answers each enable with one valid pulse after dly cycles
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fl   <= '0;
      it   <= 0;
      pend <= 1'b0;
      dcnt <= 0;
    end else begin
      fl.valid <= 1'b0;
      if (pend) begin
        if (dcnt == 0) begin
          fl.valid   <= 1'b1;
          fl.done    <= (it == nit-1);
          fl.offs[0] <= 32'(32'h100 + it);
          fl.offs[1] <= 32'(32'h200 + it);
          fl.idx[0]  <= 16'(it);
          it         <= it + 1;
          pend       <= 1'b0;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
      if (uloop_ctrl_o.enable) begin
        pend <= 1'b1;
        dcnt <= dly;
      end
      if (uloop_ctrl_o.clear) begin
        it   <= 0;
        pend <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (iter_valid_o != '0) break;
    end
    chk(nm, 64'(iter_valid_o != '0), 64'd1);
  endtask

  task automatic run_job(input string nm, input int n, input int d);
    int  en_cnt;
    int  iss_cnt;
    logic seen;
    logic [NB-1:0] pv;
    en_cnt  = 0;
    iss_cnt = 0;
    seen    = 1'b0;
    pv      = '0;
    nit     = n;
    dly     = d;
    start_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      start_i = 1'b0;
      if (uloop_ctrl_o.enable) en_cnt++;
      if (iter_valid_o != '0 && pv == '0) iss_cnt++;
      pv = iter_valid_o;
      compute_done_i = (credits_o != '0);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    compute_done_i = 1'b0;
    chk({nm, "_done"}, 64'(seen), 64'd1);
    chk({nm, "_enables"}, 64'(en_cnt), 64'(n));
    chk({nm, "_issues"}, 64'(iss_cnt), 64'(n));
    tick();
    chk({nm, "_end"}, {busy_o, credits_o, err_o}, '0);
  endtask

  typedef struct {
    logic       start;
    logic       cd;
    logic [8:0] exp;
  } vec_t;

  vec_t vec [21];
  flags_uloop_t fsave;
  logic [8:0] obs;
  int k;

  initial begin
    vec[0]  = '{1'b1, 1'b0, 9'b110000000};
    vec[1]  = '{1'b0, 1'b0, 9'b100000000};
    vec[2]  = '{1'b0, 1'b0, 9'b100000000};
    vec[3]  = '{1'b0, 1'b0, 9'b100011000};
    vec[4]  = '{1'b0, 1'b0, 9'b110000001};
    vec[5]  = '{1'b0, 1'b0, 9'b100000001};
    vec[6]  = '{1'b0, 1'b0, 9'b100000001};
    vec[7]  = '{1'b0, 1'b0, 9'b100011001};
    vec[8]  = '{1'b0, 1'b0, 9'b100000010};
    vec[9]  = '{1'b1, 1'b0, 9'b100000010};
    vec[10] = '{1'b0, 1'b0, 9'b100000010};
    vec[11] = '{1'b0, 1'b1, 9'b100000001};
    vec[12] = '{1'b0, 1'b0, 9'b110000001};
    vec[13] = '{1'b0, 1'b0, 9'b100000001};
    vec[14] = '{1'b0, 1'b0, 9'b100000001};
    vec[15] = '{1'b0, 1'b0, 9'b100011101};
    vec[16] = '{1'b0, 1'b0, 9'b100000110};
    vec[17] = '{1'b0, 1'b1, 9'b100000101};
    vec[18] = '{1'b0, 1'b1, 9'b100000100};
    vec[19] = '{1'b0, 1'b0, 9'b101100100};
    vec[20] = '{1'b0, 1'b0, 9'b000000100};

    #20;
    chk("reset_out", {busy_o, done_o, uloop_ctrl_o, iter_valid_o,
                      iter_last_o, credits_o, err_o}, '0);
    chk("reset_flags", 64'(iter_flags_o.offs), '0);
    #3 rst_ni = 1'b1;
    tick();
    chk("idle", {busy_o, uloop_ctrl_o, iter_valid_o}, '0);

    nit = 3;
    dly = 0;
    iter_ready_i = '1;
    k = 0;
    for (int i = 0; i < 21; i++) begin
      start_i        = vec[i].start;
      compute_done_i = vec[i].cd;
      tick();
      obs = {busy_o, uloop_ctrl_o.enable, uloop_ctrl_o.clear, done_o,
             iter_valid_o, iter_last_o, credits_o};
      chk($sformatf("row%0d", i), 64'(obs), 64'(vec[i].exp));
      if (vec[i].exp[4:3] != 2'b00) begin
        chk($sformatf("row%0d_offs", i), 64'(iter_flags_o.offs[0]),
            64'(32'h100 + k));
        k++;
      end
    end
    start_i        = 1'b0;
    compute_done_i = 1'b0;
    chk("table_err", 64'(err_o), 64'd0);

    nit = 1;
    iter_ready_i = 2'b01;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid("a_rise");
    chk("a_both", 64'(iter_valid_o), 64'd3);
    fsave = iter_flags_o;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("a_hold%0d", i),
          {iter_valid_o, 1'b0, iter_flags_o == fsave}, {2'b10, 2'b01});
    end
    iter_ready_i = 2'b11;
    tick();
    chk("a_exit", {iter_valid_o, credits_o}, {2'b00, 2'd1});
    compute_done_i = 1'b1;
    tick();
    compute_done_i = 1'b0;
    chk("a_ret", 64'(credits_o), 64'd0);
    tick();
    chk("a_done", {done_o, busy_o, uloop_ctrl_o.clear}, 3'b111);
    tick();
    chk("a_idle", {done_o, busy_o}, 2'b00);

    nit = 3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid("b_iss0");
    tick();
    chk("b_cred1", 64'(credits_o), 64'd1);
    wait_valid("b_iss1");
    compute_done_i = 1'b1;
    tick();
    compute_done_i = 1'b0;
    chk("b_coinc", {credits_o, err_o}, {2'd1, 1'b0});
    wait_valid("b_iss2");
    tick();
    chk("b_drain", 64'(credits_o), 64'd2);
    compute_done_i = 1'b1;
    tick();
    tick();
    compute_done_i = 1'b0;
    chk("b_zero", 64'(credits_o), 64'd0);
    tick();
    chk("b_done", 64'(done_o), 64'd1);
    tick();
    compute_done_i = 1'b1;
    tick();
    compute_done_i = 1'b0;
    chk("b_uflow", {err_o, credits_o}, {1'b1, 2'd0});
    tick();
    chk("b_sticky", 64'(err_o), 64'd1);

    iter_ready_i = 2'b00;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid("c_iss");
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("c_clear", {busy_o, iter_valid_o, uloop_ctrl_o, err_o,
                    credits_o, iter_last_o}, {1'b0, 2'b00, 3'b010, 1'b0,
                                              2'd0, 1'b0});
    tick();
    chk("c_clr_pulse", {uloop_ctrl_o, busy_o}, '0);
    iter_ready_i = 2'b11;
    run_job("c_job", 3, 0);

    run_job("p_job", 3, 4);
`ifdef HWPE_CTRL_ULOOP_SCHED_PERF_EN
    chk("perf", 64'(perf_stall_o), 64'd18);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
